aes_block_loader: RTL

- Upstream feeder for the encryptor.
- Assembles a byte-serial input stream into 128-bit key and plaintext blocks.
- Holds the current key and presents each plaintext block together with its key through a valid/ready handshake.
- Double-buffered: the next frame can be assembled while the previous block waits for the encryptor.

---
 rtl/aes_block_loader.sv | 136 +++++++++++++
 1 files changed

// File: rtl/aes_block_loader.sv
`default_nettype none
// ============================================================================
// Module      : aes_block_loader
// Description : Upstream feeder for the AES encryptor. It assembles a
//               byte-serial stream into 128-bit key and plaintext blocks,
//               holds the current key, and presents each plaintext block
//               with its key through a valid/ready handshake. The assembly
//               register is separate from the output registers, so the next
//               frame can be collected while a block waits downstream.
// Ports       : clk        - system clock, rising edge
//               rst        - asynchronous active-low reset
//               in_data    - stream byte
//               in_valid   - in_data valid this cycle
//               in_is_key  - frame type, sampled on byte 0 only (1 = key)
//               in_ready   - loader accepts a byte this cycle
//               plaintext  - assembled plaintext block
//               key        - current cipher key
//               blk_valid  - plaintext/key pair valid
//               blk_ready  - encryptor accepts the pair
//               key_loaded - a key frame has completed since reset
//               err        - sticky: plaintext dropped for lack of a key
// Revision    : 1.0 - initial release
// ============================================================================
module aes_block_loader #(
    parameter int KEY_REQUIRED = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [7:0]   in_data,
    input  logic         in_valid,
    input  logic         in_is_key,
    output logic         in_ready,
    output logic [127:0] plaintext,
    output logic [127:0] key,
    output logic         blk_valid,
    input  logic         blk_ready,
    output logic         key_loaded,
    output logic         err
);

    typedef enum logic [0:0] {
        S_FILL = 1'b0,
        S_DONE = 1'b1
    } state_t;

    state_t         state_q;
    logic [3:0]     cnt_q;
    logic [127:0]   asm_q;
    logic           is_key_q;
    logic [127:0]   pt_q;
    logic [127:0]   key_q;
    logic           blk_valid_q;
    logic           key_loaded_q;
    logic           err_q;

    logic           w_accept;
    logic           w_drain;
    logic [6:0]     w_bit_hi;

    // in_ready is the only combinational output. Gating with rst keeps it
    // low while reset is held even though the state is already FILL.
    assign in_ready = rst & (state_q == S_FILL);
    assign w_accept = in_valid & in_ready;
    assign w_drain  = blk_valid_q & blk_ready;
    // First byte lands in the MSB (AES byte order).
    assign w_bit_hi = 7'd127 - {cnt_q, 3'b000};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_FILL;
            cnt_q        <= 4'd0;
            asm_q        <= 128'd0;
            is_key_q     <= 1'b0;
            pt_q         <= 128'd0;
            key_q        <= 128'd0;
            blk_valid_q  <= 1'b0;
            key_loaded_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            // Default drain; a plaintext resolution below overrides it so a
            // drain and a reload on the same edge keep blk_valid high.
            if (w_drain) begin
                blk_valid_q <= 1'b0;
            end

            case (state_q)
                S_FILL: begin
                    if (w_accept) begin
                        asm_q[w_bit_hi -: 8] <= in_data;
                        cnt_q                <= cnt_q + 4'd1;
                        if (cnt_q == 4'd0) begin
                            is_key_q <= in_is_key;
                        end
                        if (cnt_q == 4'd15) begin
                            state_q <= S_DONE;
                        end
                    end
                end

                S_DONE: begin
                    if (is_key_q) begin
                        // Never re-key a pair that is still waiting.
                        if (!blk_valid_q) begin
                            key_q        <= asm_q;
                            key_loaded_q <= 1'b1;
                            state_q      <= S_FILL;
                            cnt_q        <= 4'd0;
                        end
                    end else if (!key_loaded_q && (KEY_REQUIRED != 0)) begin
                        err_q   <= 1'b1;
                        state_q <= S_FILL;
                        cnt_q   <= 4'd0;
                    end else if (!blk_valid_q || w_drain) begin
                        pt_q        <= asm_q;
                        blk_valid_q <= 1'b1;
                        state_q     <= S_FILL;
                        cnt_q       <= 4'd0;
                    end
                end

                default: begin
                    state_q <= S_FILL;
                    cnt_q   <= 4'd0;
                end
            endcase
        end
    end

    assign plaintext  = pt_q;
    assign key        = key_q;
    assign blk_valid  = blk_valid_q;
    assign key_loaded = key_loaded_q;
    assign err        = err_q;

endmodule
`default_nettype wire
